uart_tx_block: RTL
==================

Name: uart_tx_block

Overview:
- Serial UART transmitter with the same frame format the receive path accepts: one start bit (0), 5–8 data bits LSB-first, one stop bit (1).
- Runtime bit_period and data_size use the encoding of the APB configuration registers, so one configuration can drive TX and RX in loopback.
- Sits upstream of the receiver; its serial_out feeds rcv_block's serial_in.
- Has a one-entry holding buffer, so frames can be sent back-to-back with no idle gap.

Parameters:
- BP_WIDTH, 14, width of the bit_period input.
- MAX_DATA, 8, maximum data bits per frame; also the width of tx_data.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  word to send; bit 0 is sent first.
- tx_valid  in  1  producer has a word on tx_data.
- tx_ready  out  1  holding buffer is empty; the word is accepted on a rising edge with tx_valid && tx_ready.
- data_size  in  4  data bits per frame; valid range 5–8.
- bit_period  in  14  clock cycles per serial bit.
- serial_out  out  1  registered serial line; idles at 1.
- tx_busy  out  1  a frame is in flight (state is not IDLE).
- tx_done  out  1  single-cycle pulse in the last cycle of every stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - FSM goes to IDLE; holding buffer is emptied; counters are cleared.
  - Reset mid-frame abandons the frame; the line returns to 1 at once.
- Effective configuration:
  - eff_period = (bit_period==0) ? 1 : bit_period.
  - eff_size = (data_size<5 || data_size>8) ? 8 : data_size.
  - Both are latched when a frame is loaded. Changing the inputs mid-frame has no effect until the next load.
- FSM states: IDLE, START, DATA, STOP.
- Accept:
  - In IDLE with the buffer empty, an accepted word loads straight into the shift register. The FSM moves to START and serial_out=0 from the next cycle (latency 1 clock). tx_ready stays 1.
  - In any other state, an accepted word goes into the holding buffer and tx_ready drops to 0 the next cycle.
- Bit timing:
  - A cycle counter runs 1..eff_period; each bit is held for exactly eff_period cycles.
  - A frame lasts (eff_size+2)*eff_period cycles.
- START → DATA after eff_period cycles.
- DATA:
  - serial_out = shift[0]; the register shifts right at the end of each bit.
  - A bit counter counts to eff_size, then the FSM moves to STOP.
- STOP:
  - serial_out=1 for eff_period cycles.
  - tx_done=1 in the last cycle.
  - If the buffer is full: load it into the shift register, relatch the configuration, set tx_ready=1 next cycle, and go to START. No idle cycles between frames.
  - Otherwise go to IDLE.
- Simultaneous accept and buffer drain in the final STOP cycle: the buffer is full, so tx_ready=0 and no accept occurs. The drain happens; the new word is accepted on a later edge.
- tx_valid while tx_ready=0: the word is ignored. The producer must hold tx_data/tx_valid until the handshake completes.
- Bits of tx_data above eff_size are ignored.
- Counter wrap: the cycle counter is BP_WIDTH bits wide. bit_period=16383 must work without overflow.

Test Plan:
- Basic frame, bit_period=10, data_size=8, tx_data=0xD5:
  - serial_out: 0 for 10 clocks, then 1,0,1,0,1,0,1,1 each 10 clocks, then 1 for 10 clocks.
  - tx_done pulses at cycle 100.
  - In loopback, rcv_block gives rx_data=0xD5, framing_error=0.
- Short word, data_size=5, tx_data=0x15:
  - Frame is 70 clocks, data bits 1,0,1,0,1.
  - data_size=9 with 0xA5 is sent as an 8-bit frame of 100 clocks.
- Back-to-back frames 0x55 then 0x33:
  - Second word is accepted during frame 1 and tx_ready=0 until the final STOP cycle.
  - Frame 2's start bit begins the cycle right after frame 1's stop bit; no idle gap.
  - A third offer while tx_ready=0 is not accepted.
- Edge periods:
  - bit_period=1, 8 bits: 10-clock frame.
  - bit_period=0 behaves the same as 1.
  - bit_period=0x3FFF keeps the start bit for exactly 16383 clocks.
- Reset mid-frame in DATA with a word in the buffer:
  - serial_out=1 and tx_ready=1 without waiting for a clock edge.
  - No tx_done pulse; the next accepted frame is transmitted cleanly.

Source files
------------

// File: rtl/uart_tx_block.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_block : UART transmitter, 1 start / 5-8 data (LSB first) / 1 stop,
//                 with a one-entry holding buffer for back-to-back frames.
// Revision      : 1.0
// ---------------------------------------------------------------------------
module uart_tx_block #(
    parameter int BP_WIDTH = 14,
    parameter int MAX_DATA = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAX_DATA-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [3:0]          data_size,
    input  logic [BP_WIDTH-1:0] bit_period,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_d;
    logic [MAX_DATA-1:0]   shift_q, shift_d;
    logic [MAX_DATA-1:0]   hold_q, hold_d;
    logic                  hold_full, hold_full_d;
    logic [BP_WIDTH-1:0]   cyc_q, cyc_d;
    logic [3:0]            bit_q, bit_d;
    logic [BP_WIDTH-1:0]   per_q, per_d;
    logic [3:0]            size_q, size_d;
    logic                  serial_q, serial_d;

    logic                  accept;
    logic                  bit_end;
    logic                  load;
    logic [MAX_DATA-1:0]   load_word;
    logic [BP_WIDTH-1:0]   eff_period;
    logic [3:0]            eff_size;

    assign eff_period = (bit_period == '0) ? BP_WIDTH'(1) : bit_period;
    assign eff_size   = (data_size < 4'd5 || data_size > 4'(MAX_DATA)) ? 4'(MAX_DATA) : data_size;
    assign accept     = tx_valid && !hold_full;
    assign bit_end    = (cyc_q == per_q);

    always_comb begin
        state_d     = state;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full;
        cyc_d       = cyc_q;
        bit_d       = bit_q;
        per_d       = per_q;
        size_d      = size_q;
        load        = 1'b0;
        load_word   = tx_data;

        if (state == IDLE) begin
            // A word parked in the buffer (accepted in the final STOP cycle) goes first.
            if (hold_full) begin
                load        = 1'b1;
                load_word   = hold_q;
                hold_full_d = 1'b0;
            end else if (accept) begin
                load      = 1'b1;
                load_word = tx_data;
            end
        end else begin
            if (accept) begin
                hold_d      = tx_data;
                hold_full_d = 1'b1;
            end
            cyc_d = bit_end ? BP_WIDTH'(1) : cyc_q + BP_WIDTH'(1);
            case (state)
                START: begin
                    if (bit_end) begin
                        state_d = DATA;
                        bit_d   = 4'd0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_d = shift_q >> 1;
                        if (bit_q == size_q - 4'd1) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (hold_full) begin
                            load        = 1'b1;
                            load_word   = hold_q;
                            hold_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            shift_d = load_word;
            per_d   = eff_period;
            size_d  = eff_size;
            cyc_d   = BP_WIDTH'(1);
            bit_d   = 4'd0;
            state_d = START;
        end

        // The line register follows the state being entered so it lines up with it.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_q   <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            cyc_q     <= '0;
            bit_q     <= '0;
            per_q     <= BP_WIDTH'(1);
            size_q    <= 4'(MAX_DATA);
            serial_q  <= 1'b1;
        end else begin
            state     <= state_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            hold_full <= hold_full_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            per_q     <= per_d;
            size_q    <= size_d;
            serial_q  <= serial_d;
        end
    end

    assign serial_out = serial_q;
    assign tx_ready   = !hold_full;
    assign tx_busy    = (state != IDLE);
    assign tx_done    = (state == STOP) && bit_end;

endmodule
`default_nettype wire
